// File: rtl/ps2_modbus_frame_ctrl_module.sv
// PS/2 scan-code to Modbus frame controller.
// Queues filtered scan codes, wraps each in a 7-byte frame closed by a
// CRC-16/Modbus (computed one bit per cycle) and hands the frame to a
// UART transmitter one byte at a time over an En/Done handshake.
module ps2_modbus_frame_ctrl_module #(
  parameter logic [7:0]  SLAVE_ADDR  = 8'h01,
  parameter logic [7:0]  FUNC_CODE   = 8'h06,
  parameter logic [15:0] REG_ADDR    = 16'h0000,
  parameter int          QDEPTH_LOG2 = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic [7:0] PS2_Data,
  input  logic       PS2_Done_Sig,
  input  logic       TX_Done_Sig,
  input  logic       Ovf_Clr_Sig,
  output logic       TX_En_Sig,
  output logic [7:0] TX_Data,
  output logic       Busy_Sig,
  output logic       Overflow_Sig
);

  localparam int QDEPTH = 1 << QDEPTH_LOG2;
  localparam logic [QDEPTH_LOG2:0] PTR_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CRC  = 3'd2,
    S_SEND = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [7:0]             fifo_q [QDEPTH];
  logic [QDEPTH_LOG2:0]   wr_ptr_q, rd_ptr_q;
  logic                   full_s, empty_s, code_ok_s, push_s, pop_s, drop_s;

  logic [7:0]  scan_q, scan_d;
  logic [15:0] crc_q, crc_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  crc_byte_s;
  logic [15:0] crc_mix_s, crc_step_s;

  logic        tx_en_d, busy_d, ovf_d;
  logic [7:0]  tx_data_d;

  // Byte at position idx of the frame being built/sent.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                            input logic [7:0] scan,
                                            input logic [15:0] crc);
    logic [7:0] b;
    case (idx)
      3'd0:    b = SLAVE_ADDR;
      3'd1:    b = FUNC_CODE;
      3'd2:    b = REG_ADDR[15:8];
      3'd3:    b = REG_ADDR[7:0];
      3'd4:    b = scan;
      3'd5:    b = crc[7:0];
      3'd6:    b = crc[15:8];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // One reflected CRC-16/Modbus shift step.
  function automatic logic [15:0] crc_shift(input logic [15:0] c);
    logic [15:0] r;
    if (c[0]) begin
      r = (c >> 1) ^ 16'hA001;
    end else begin
      r = c >> 1;
    end
    return r;
  endfunction

  assign empty_s   = (wr_ptr_q == rd_ptr_q);
  assign full_s    = (wr_ptr_q[QDEPTH_LOG2] != rd_ptr_q[QDEPTH_LOG2]) &&
                     (wr_ptr_q[QDEPTH_LOG2-1:0] == rd_ptr_q[QDEPTH_LOG2-1:0]);
  // Break codes (F0) and null codes never enter the queue.
  assign code_ok_s = PS2_Done_Sig && (PS2_Data != 8'h00) && (PS2_Data != 8'hF0);
  assign pop_s     = (state_q == S_LOAD);
  // A pop in the same cycle frees a slot, so a push on a full queue still fits.
  assign push_s    = code_ok_s && (!full_s || pop_s);
  assign drop_s    = code_ok_s && full_s && !pop_s;

  // Serial CRC: fold the next byte in on its first bit, then shift once.
  assign crc_byte_s = frame_byte(bit_cnt_q[5:3], scan_q, crc_q);
  assign crc_mix_s  = (bit_cnt_q[2:0] == 3'd0) ? (crc_q ^ {8'h00, crc_byte_s}) : crc_q;
  assign crc_step_s = crc_shift(crc_mix_s);

  // Scan-code queue storage and pointers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo_q[i] <= 8'h00;
      end
    end else begin
      if (push_s) begin
        fifo_q[wr_ptr_q[QDEPTH_LOG2-1:0]] <= PS2_Data;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a waiting code chains straight from the last GAP into LOAD.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!empty_s) state_d = S_LOAD;
        else          state_d = S_IDLE;
      end
      S_LOAD: state_d = S_CRC;
      S_CRC: begin
        if (bit_cnt_q == 6'd39) state_d = S_SEND;
        else                    state_d = S_CRC;
      end
      S_SEND: begin
        if (TX_Done_Sig) state_d = S_GAP;
        else             state_d = S_SEND;
      end
      S_GAP: begin
        if (idx_q == 3'd6) begin
          if (!empty_s) state_d = S_LOAD;
          else          state_d = S_IDLE;
        end else begin
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Frame datapath next values: captured scan code, CRC, bit counter, byte index.
  always_comb begin
    scan_d    = scan_q;
    crc_d     = crc_q;
    bit_cnt_d = bit_cnt_q;
    idx_d     = idx_q;
    case (state_q)
      S_LOAD: begin
        scan_d    = fifo_q[rd_ptr_q[QDEPTH_LOG2-1:0]];
        crc_d     = 16'hFFFF;
        bit_cnt_d = 6'd0;
        idx_d     = 3'd0;
      end
      S_CRC: begin
        crc_d     = crc_step_s;
        bit_cnt_d = bit_cnt_q + 6'd1;
      end
      S_GAP: begin
        if (idx_q != 3'd6) idx_d = idx_q + 3'd1;
        else               idx_d = idx_q;
      end
      default: begin
        scan_d = scan_q;
      end
    endcase
  end

  // Frame datapath registers.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scan_q    <= 8'h00;
      crc_q     <= 16'hFFFF;
      bit_cnt_q <= 6'd0;
      idx_q     <= 3'd0;
    end else begin
      scan_q    <= scan_d;
      crc_q     <= crc_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
    end
  end

  // Output next values, derived from the upcoming state so outputs can be registered.
  always_comb begin
    tx_en_d   = 1'b0;
    tx_data_d = 8'h00;
    busy_d    = (state_d != S_IDLE);
    if (state_d == S_SEND) begin
      tx_en_d   = 1'b1;
      tx_data_d = frame_byte(idx_d, scan_d, crc_d);
    end else begin
      tx_en_d   = 1'b0;
      tx_data_d = 8'h00;
    end
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (Ovf_Clr_Sig) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = Overflow_Sig;
    end
  end

  // Registered outputs.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      TX_En_Sig    <= 1'b0;
      TX_Data      <= 8'h00;
      Busy_Sig     <= 1'b0;
      Overflow_Sig <= 1'b0;
    end else begin
      TX_En_Sig    <= tx_en_d;
      TX_Data      <= tx_data_d;
      Busy_Sig     <= busy_d;
      Overflow_Sig <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_modbus_frame_ctrl_module.sv
// Directed testbench for ps2_modbus_frame_ctrl_module.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ps2_modbus_frame_ctrl_module;

  logic       CLK = 1'b0;
  logic       RSTn = 1'b0;
  logic [7:0] PS2_Data = 8'h00;
  logic       PS2_Done_Sig = 1'b0;
  logic       TX_Done_Sig = 1'b0;
  logic       Ovf_Clr_Sig = 1'b0;
  logic       TX_En_Sig;
  logic [7:0] TX_Data;
  logic       Busy_Sig;
  logic       Overflow_Sig;

  int nvec = 0;
  int nerr = 0;

  localparam int ACK_DLY = 5;
  localparam int WAIT_MAX = 300;

  ps2_modbus_frame_ctrl_module dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .PS2_Data     (PS2_Data),
    .PS2_Done_Sig (PS2_Done_Sig),
    .TX_Done_Sig  (TX_Done_Sig),
    .Ovf_Clr_Sig  (Ovf_Clr_Sig),
    .TX_En_Sig    (TX_En_Sig),
    .TX_Data      (TX_Data),
    .Busy_Sig     (Busy_Sig),
    .Overflow_Sig (Overflow_Sig)
  );

  always #5 CLK = ~CLK;

  // Reference frame (byte0 in bits [7:0]) using a byte-wise CRC-16/Modbus.
  function automatic logic [55:0] exp_frame(input logic [7:0] c);
    logic [7:0]  b [5];
    logic [15:0] crc;
    b[0] = 8'h01; b[1] = 8'h06; b[2] = 8'h00; b[3] = 8'h00; b[4] = c;
    crc = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      crc = crc ^ {8'h00, b[i]};
      for (int j = 0; j < 8; j++) begin
        if (crc[0]) crc = (crc >> 1) ^ 16'hA001;
        else        crc = crc >> 1;
      end
    end
    return {crc[15:8], crc[7:0], c, 8'h00, 8'h00, 8'h06, 8'h01};
  endfunction

  // One-cycle scan-code strobe; call and return on a falling edge.
  task automatic push(input logic [7:0] c);
    PS2_Data = c;
    PS2_Done_Sig = 1'b1;
    @(negedge CLK);
    PS2_Done_Sig = 1'b0;
  endtask

  // Wait for TX_En, capture the byte, ack ACK_DLY cycles later, note the GAP level.
  task automatic recv_byte(output logic [7:0] b, output int waited, output bit gap_low);
    waited = 0;
    while (!TX_En_Sig && waited < WAIT_MAX) begin
      @(negedge CLK);
      waited++;
    end
    b = TX_Data;
    repeat (ACK_DLY - 1) @(negedge CLK);
    TX_Done_Sig = 1'b1;
    @(negedge CLK);
    TX_Done_Sig = 1'b0;
    gap_low = !TX_En_Sig;
  endtask

  // Receive 7 bytes; ok is set when every later byte came one GAP after the ack.
  task automatic recv_frame(output logic [55:0] fr, output int first_wait, output bit ok);
    logic [7:0] b;
    int w;
    bit g;
    ok = 1'b1;
    fr = '0;
    first_wait = 0;
    for (int i = 0; i < 7; i++) begin
      recv_byte(b, w, g);
      fr[8*i +: 8] = b;
      if (i == 0) first_wait = w;
      else if (w != 1) ok = 1'b0;
      if (!g || w >= WAIT_MAX) ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    nvec++;
    if ({TX_En_Sig, TX_Data, Busy_Sig, Overflow_Sig} !== 11'h000) begin
      $display("FAIL reset_outputs: got en=%b data=%h busy=%b ovf=%b expected all 0",
               TX_En_Sig, TX_Data, Busy_Sig, Overflow_Sig);
      nerr++;
    end
    RSTn = 1'b1;
    repeat (2) @(negedge CLK);
    nvec++;
    if (Busy_Sig !== 1'b0 || TX_En_Sig !== 1'b0) begin
      $display("FAIL idle_after_reset: got busy=%b en=%b expected 0 0", Busy_Sig, TX_En_Sig);
      nerr++;
    end
  endtask

  task automatic test_single_frame();
    logic [55:0] fr;
    int w;
    bit ok;
    push(8'h1C);
    recv_frame(fr, w, ok);
    nvec++;
    if (w != 42) begin
      $display("FAIL latency: got %0d cycles expected 42", w);
      nerr++;
    end
    nvec++;
    if (fr !== {8'h81, 8'h18, 8'h1C, 8'h00, 8'h00, 8'h06, 8'h01}) begin
      $display("FAIL frame_1C: got %h expected 81181c00000601", fr);
      nerr++;
    end
    nvec++;
    if (!ok) begin
      $display("FAIL handshake_1C: got ok=%b expected 1", ok);
      nerr++;
    end
    nvec++;
    if (Busy_Sig !== 1'b1) begin
      $display("FAIL busy_in_gap: got %b expected 1", Busy_Sig);
      nerr++;
    end
    @(negedge CLK);
    nvec++;
    if (Busy_Sig !== 1'b0) begin
      $display("FAIL busy_after_gap: got %b expected 0", Busy_Sig);
      nerr++;
    end
  endtask

  task automatic test_filter();
    bit seen = 1'b0;
    push(8'hF0);
    push(8'h00);
    repeat (60) begin
      @(negedge CLK);
      if (TX_En_Sig || Busy_Sig) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0 || Overflow_Sig !== 1'b0) begin
      $display("FAIL filter: got activity=%b ovf=%b expected 0 0", seen, Overflow_Sig);
      nerr++;
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  codes [6];
    logic [55:0] fr;
    int w;
    bit ok;
    codes[0] = 8'h11; codes[1] = 8'h22; codes[2] = 8'h33;
    codes[3] = 8'h44; codes[4] = 8'h55; codes[5] = 8'h66;
    for (int i = 0; i < 6; i++) push(codes[i]);
    nvec++;
    if (Overflow_Sig !== 1'b1) begin
      $display("FAIL ovf_set: got %b expected 1", Overflow_Sig);
      nerr++;
    end
    for (int i = 0; i < 5; i++) begin
      recv_frame(fr, w, ok);
      nvec++;
      if (fr !== exp_frame(codes[i]) || !ok) begin
        $display("FAIL ovf_frame%0d: got %h ok=%b expected %h ok=1", i, fr, ok, exp_frame(codes[i]));
        nerr++;
      end
    end
    repeat (3) @(negedge CLK);
    nvec++;
    if (Busy_Sig !== 1'b0 || Overflow_Sig !== 1'b1) begin
      $display("FAIL ovf_after_drain: got busy=%b ovf=%b expected 0 1", Busy_Sig, Overflow_Sig);
      nerr++;
    end
    Ovf_Clr_Sig = 1'b1;
    @(negedge CLK);
    Ovf_Clr_Sig = 1'b0;
    nvec++;
    if (Overflow_Sig !== 1'b0) begin
      $display("FAIL ovf_clear: got %b expected 0", Overflow_Sig);
      nerr++;
    end
  endtask

  task automatic test_push_on_pop();
    logic [7:0]  codes [6];
    logic [55:0] fr;
    int w;
    bit ok;
    codes[0] = 8'hA1; codes[1] = 8'hB2; codes[2] = 8'hC3;
    codes[3] = 8'hD4; codes[4] = 8'hE5; codes[5] = 8'hF6;
    push(codes[0]);
    repeat (3) @(negedge CLK);
    for (int i = 1; i < 5; i++) push(codes[i]);
    recv_frame(fr, w, ok);
    nvec++;
    if (fr !== exp_frame(codes[0]) || !ok) begin
      $display("FAIL pop_frame0: got %h ok=%b expected %h ok=1", fr, ok, exp_frame(codes[0]));
      nerr++;
    end
    // Now in GAP of byte6; next cycle is LOAD, whose pop edge samples this push.
    @(negedge CLK);
    push(codes[5]);
    nvec++;
    if (Overflow_Sig !== 1'b0) begin
      $display("FAIL pop_push_ovf: got %b expected 0", Overflow_Sig);
      nerr++;
    end
    for (int i = 1; i < 6; i++) begin
      recv_frame(fr, w, ok);
      nvec++;
      if (fr !== exp_frame(codes[i]) || !ok) begin
        $display("FAIL pop_frame%0d: got %h ok=%b expected %h ok=1", i, fr, ok, exp_frame(codes[i]));
        nerr++;
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_done_in_crc();
    logic [55:0] fr;
    int w;
    bit ok;
    push(8'h2D);
    repeat (10) @(negedge CLK);
    TX_Done_Sig = 1'b1;
    @(negedge CLK);
    TX_Done_Sig = 1'b0;
    recv_frame(fr, w, ok);
    nvec++;
    if (w != 31) begin
      $display("FAIL crc_done_latency: got %0d expected 31", w);
      nerr++;
    end
    nvec++;
    if (fr !== exp_frame(8'h2D) || !ok) begin
      $display("FAIL crc_done_frame: got %h ok=%b expected %h ok=1", fr, ok, exp_frame(8'h2D));
      nerr++;
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] b;
    int w;
    bit g;
    bit seen = 1'b0;
    push(8'h3E);
    for (int i = 0; i < 3; i++) recv_byte(b, w, g);
    w = 0;
    while (!TX_En_Sig && w < WAIT_MAX) begin
      @(negedge CLK);
      w++;
    end
    nvec++;
    if (TX_Data !== 8'h00 || TX_En_Sig !== 1'b1) begin
      $display("FAIL byte3_before_reset: got en=%b data=%h expected 1 00", TX_En_Sig, TX_Data);
      nerr++;
    end
    RSTn = 1'b0;
    #1;
    nvec++;
    if (TX_En_Sig !== 1'b0 || Busy_Sig !== 1'b0) begin
      $display("FAIL async_reset: got en=%b busy=%b expected 0 0", TX_En_Sig, Busy_Sig);
      nerr++;
    end
    @(negedge CLK);
    RSTn = 1'b1;
    repeat (100) begin
      @(negedge CLK);
      if (TX_En_Sig || Busy_Sig) seen = 1'b1;
    end
    nvec++;
    if (seen !== 1'b0) begin
      $display("FAIL resume_after_reset: got activity=%b expected 0", seen);
      nerr++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    @(negedge CLK);
    test_reset();
    test_single_frame();
    test_filter();
    test_overflow();
    test_push_on_pop();
    test_done_in_crc();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
